// File: rtl/ap3_fifo_pkg.sv
// rtl/ap3_fifo_pkg.sv - shared flag indices, flag vector type and read-source encoding for ap3_sync_fifo
package ap3_fifo_pkg;

    localparam int FFLAGS_W     = 4;
    localparam int FFLAG_EMPTY  = 0;
    localparam int FFLAG_AEMPTY = 1;
    localparam int FFLAG_AFULL  = 2;
    localparam int FFLAG_FULL   = 3;

    typedef logic [FFLAGS_W-1:0] fflags_t;

    // Which register drives RDATA in first-word-fall-through mode
    typedef enum logic {
        SRC_MEM = 1'b0,
        SRC_BYP = 1'b1
    } rd_src_t;

    function automatic fflags_t pack_flags(input logic full, input logic afull,
                                           input logic aempty, input logic empty);
        fflags_t f;
        f               = '0;
        f[FFLAG_FULL]   = full;
        f[FFLAG_AFULL]  = afull;
        f[FFLAG_AEMPTY] = aempty;
        f[FFLAG_EMPTY]  = empty;
        return f;
    endfunction

endpackage

// File: rtl/ap3_fifo_mem.sv
// rtl/ap3_fifo_mem.sv - simple dual-port storage, synchronous write, registered read
// The read register resets to zero and holds its value when no read is issued.
module ap3_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ap3_sync_fifo.sv
// rtl/ap3_sync_fifo.sv - parametrised single-clock FIFO with thresholds, flush, sticky errors and count
// Define AP3_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle-latency reads.
module ap3_sync_fifo
    import ap3_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 QCK,
    input  logic                 QRT,
    input  logic                 WEN,
    input  logic [WIDTH-1:0]     WDATA,
    input  logic                 REN,
    output logic [WIDTH-1:0]     RDATA,
    output logic                 RVALID,
    input  logic                 FFLUSH,
    input  logic [ADDR_W-1:0]    UPAE,
    input  logic [ADDR_W-1:0]    UPAF,
    output logic [FFLAGS_W-1:0]  FFLAGS,
    output logic [ADDR_W:0]      COUNT,
    output logic                 OVERFLOW,
    output logic                 UNDERFLOW
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   count;
    logic              ovf;
    logic              unf;
    logic              empty;
    logic              full;
    logic              aempty;
    logic              afull;
    logic              wr_acc;
    logic              rd_acc;
    logic              mem_we;
    logic              mem_re;
    logic [WIDTH-1:0]  mem_rdata;

    // Full/empty come from the occupancy count, so pointer equality is never ambiguous
    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign aempty = (count <= {1'b0, UPAE});
    assign afull  = (count >= (FULL_CNT - {1'b0, UPAF}));

    assign wr_acc = WEN && !full && !FFLUSH;

    ap3_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (QCK),
        .rst   (QRT),
        .we    (mem_we),
        .waddr (wptr),
        .wdata (WDATA),
        .re    (mem_re),
        .raddr (rptr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge QCK) begin
        if (QRT || FFLUSH) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (mem_we) begin
                wptr <= wptr + PTR_ONE;
            end
            if (mem_re) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            ovf <= ovf || (WEN && full);
            unf <= unf || (REN && empty);
        end
    end

`ifdef AP3_FIFO_FWFT_EN
    logic             ovalid;
    rd_src_t          src;
    logic [WIDTH-1:0] byp_data;
    logic [ADDR_W:0]  ram_cnt;
    logic             refill;
    logic             byp_ld;

    // count includes the presented head word; ram_cnt is what is still in storage
    assign rd_acc  = REN && ovalid && !FFLUSH;
    assign ram_cnt = count - {{ADDR_W{1'b0}}, ovalid};
    assign refill  = !ovalid || rd_acc;
    assign mem_re  = refill && (ram_cnt != '0) && !FFLUSH;
    assign byp_ld  = refill && (ram_cnt == '0) && wr_acc;
    assign mem_we  = wr_acc && !byp_ld;

    always_ff @(posedge QCK) begin
        if (QRT) begin
            ovalid   <= 1'b0;
            src      <= SRC_BYP;
            byp_data <= '0;
        end else if (FFLUSH) begin
            ovalid <= 1'b0;
        end else if (mem_re) begin
            ovalid <= 1'b1;
            src    <= SRC_MEM;
        end else if (byp_ld) begin
            ovalid   <= 1'b1;
            src      <= SRC_BYP;
            byp_data <= WDATA;
        end else if (rd_acc) begin
            ovalid <= 1'b0;
        end
    end

    assign RVALID = ovalid;
    assign RDATA  = (src == SRC_BYP) ? byp_data : mem_rdata;
`else
    logic rvalid;

    assign rd_acc = REN && !empty && !FFLUSH;
    assign mem_re = rd_acc;
    assign mem_we = wr_acc;

    always_ff @(posedge QCK) begin
        if (QRT || FFLUSH) begin
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_acc;
        end
    end

    assign RVALID = rvalid;
    assign RDATA  = mem_rdata;
`endif

    assign FFLAGS    = pack_flags(full, afull, aempty, empty);
    assign COUNT     = count;
    assign OVERFLOW  = ovf;
    assign UNDERFLOW = unf;

endmodule

// File: tb/tb_ap3_sync_fifo.sv
// tb/tb_ap3_sync_fifo.sv - table-driven and scoreboard checks of ap3_sync_fifo at WIDTH=8, DEPTH=8
module tb_ap3_sync_fifo;

    logic       clk = 1'b0;
    logic       qrt = 1'b1;
    logic       wen = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       ren = 1'b0;
    logic [7:0] rdata;
    logic       rvalid;
    logic       flush = 1'b0;
    logic [2:0] upae = 3'd1;
    logic [2:0] upaf = 3'd2;
    logic [3:0] fflags;
    logic [3:0] count;
    logic       ovf;
    logic       unf;

    int         n_vec  = 0;
    int         n_fail = 0;
    logic [7:0] sb[$];
    logic [7:0] last_pop = 8'h00;

    always #5 clk = ~clk;

    ap3_sync_fifo #(
        .WIDTH (8),
        .DEPTH (8)
    ) dut (
        .QCK       (clk),
        .QRT       (qrt),
        .WEN       (wen),
        .WDATA     (wdata),
        .REN       (ren),
        .RDATA     (rdata),
        .RVALID    (rvalid),
        .FFLUSH    (flush),
        .UPAE      (upae),
        .UPAF      (upaf),
        .FFLAGS    (fflags),
        .COUNT     (count),
        .OVERFLOW  (ovf),
        .UNDERFLOW (unf)
    );

    typedef struct {
        logic       w;
        logic       r;
        logic [7:0] d;
        logic       push;
        logic [3:0] cnt;
        logic [3:0] flags;
        logic       ovf;
        logic       unf;
        logic       rv;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic w, input logic r, input logic [7:0] d, input logic push,
                                input logic [3:0] cnt, input logic [3:0] flags,
                                input logic o, input logic u, input logic rv);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.push = push; v.cnt = cnt; v.flags = flags;
        v.ovf = o; v.unf = u; v.rv = rv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_read(input string name, input logic exp_rv);
        check({name, "_rvalid"}, 32'(rvalid), 32'(exp_rv));
        if (rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                check({name, "_sb_empty"}, 32'(1), 32'(0));
            end else begin
                last_pop = sb.pop_front();
                check({name, "_rdata"}, 32'(rdata), 32'(last_pop));
            end
        end
    endtask

    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f);
        wen = w; wdata = d; ren = r; flush = f;
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        qrt = 1'b1;
        cyc(1'b1, 8'hFF, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        qrt = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_flags", 32'(fflags), 32'h3);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_unf", 32'(unf), 32'd0);

`ifdef AP3_FIFO_FWFT_EN
        sb.push_back(8'hA5);
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        check("fwft_count1", 32'(count), 32'd1);
        check_read("fwft_fall", 1'b1);
        sb.push_back(8'hA5);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_read("fwft_hold", 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_read("fwft_pop", 1'b0);
        check("fwft_flags0", 32'(fflags), 32'h3);
        check("fwft_count0", 32'(count), 32'd0);
        sb.push_back(8'h11);
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        check_read("fwft_head", 1'b1);
        sb.push_back(8'h22);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_read("fwft_next", 1'b1);
        check("fwft_count_next", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_read("fwft_last", 1'b0);
        check("fwft_unf", 32'(unf), 32'd0);
`else
        // UPAE=1, UPAF=2: AEMPTY at count<=1, AFULL at count>=6
        tbl[0]  = mk(1, 0, 8'h01, 1, 4'd1, 4'b0010, 0, 0, 0);
        tbl[1]  = mk(1, 0, 8'h02, 1, 4'd2, 4'b0000, 0, 0, 0);
        tbl[2]  = mk(1, 0, 8'h03, 1, 4'd3, 4'b0000, 0, 0, 0);
        tbl[3]  = mk(1, 0, 8'h04, 1, 4'd4, 4'b0000, 0, 0, 0);
        tbl[4]  = mk(1, 0, 8'h05, 1, 4'd5, 4'b0000, 0, 0, 0);
        tbl[5]  = mk(1, 0, 8'h06, 1, 4'd6, 4'b0100, 0, 0, 0);
        tbl[6]  = mk(1, 0, 8'h07, 1, 4'd7, 4'b0100, 0, 0, 0);
        tbl[7]  = mk(1, 0, 8'h08, 1, 4'd8, 4'b1100, 0, 0, 0);
        tbl[8]  = mk(1, 0, 8'h09, 0, 4'd8, 4'b1100, 1, 0, 0);
        tbl[9]  = mk(0, 1, 8'h00, 0, 4'd7, 4'b0100, 1, 0, 1);
        tbl[10] = mk(0, 1, 8'h00, 0, 4'd6, 4'b0100, 1, 0, 1);
        tbl[11] = mk(0, 1, 8'h00, 0, 4'd5, 4'b0000, 1, 0, 1);
        tbl[12] = mk(0, 1, 8'h00, 0, 4'd4, 4'b0000, 1, 0, 1);
        tbl[13] = mk(0, 1, 8'h00, 0, 4'd3, 4'b0000, 1, 0, 1);
        tbl[14] = mk(0, 1, 8'h00, 0, 4'd2, 4'b0000, 1, 0, 1);
        tbl[15] = mk(0, 1, 8'h00, 0, 4'd1, 4'b0010, 1, 0, 1);
        tbl[16] = mk(0, 1, 8'h00, 0, 4'd0, 4'b0011, 1, 0, 1);
        tbl[17] = mk(0, 1, 8'h00, 0, 4'd0, 4'b0011, 1, 1, 0);

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].push) sb.push_back(tbl[i].d);
            cyc(tbl[i].w, tbl[i].d, tbl[i].r, 1'b0);
            check($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            check($sformatf("v%0d_flags", i), 32'(fflags), 32'(tbl[i].flags));
            check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
            check($sformatf("v%0d_unf", i), 32'(unf), 32'(tbl[i].unf));
            check_read($sformatf("v%0d", i), tbl[i].rv);
        end

        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("flush0_errs", 32'({ovf, unf}), 32'd0);
        check("flush0_rdata", 32'(rdata), 32'h08);

        // Steady state at COUNT=4 across pointer wrap
        for (int i = 0; i < 4; i++) begin
            sb.push_back(8'(8'h10 + i));
            cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            sb.push_back(8'(8'h20 + i));
            cyc(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
            check($sformatf("rw%0d_count", i), 32'(count), 32'd4);
            check_read($sformatf("rw%0d", i), 1'b1);
        end
        check("rw_flags", 32'(fflags), 32'h0);
        check("rw_errs", 32'({ovf, unf}), 32'd0);

        for (int i = 0; i < 4; i++) begin
            sb.push_back(8'(8'h40 + i));
            cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        check("full_flags", 32'(fflags), 32'hC);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        check("rwfull_count", 32'(count), 32'd7);
        check("rwfull_ovf", 32'(ovf), 32'd1);
        check_read("rwfull", 1'b1);

        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_read("drain_a", 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_read("drain_b", 1'b1);
        check("pre_flush_count", 32'(count), 32'd5);

        cyc(1'b1, 8'h77, 1'b1, 1'b1);
        sb.delete();
        check("flush_count", 32'(count), 32'd0);
        check("flush_flags", 32'(fflags), 32'h3);
        check("flush_errs", 32'({ovf, unf}), 32'd0);
        check("flush_rvalid", 32'(rvalid), 32'd0);
        check("flush_rdata", 32'(rdata), 32'(last_pop));

        sb.push_back(8'h5A);
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        check("post_flags", 32'(fflags), 32'h2);
        upae = 3'd0;
        #1;
        check("upae_live", 32'(fflags), 32'h0);
        upaf = 3'd7;
        #1;
        check("upaf_live", 32'(fflags), 32'h4);
        upae = 3'd1;
        upaf = 3'd2;
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_read("post", 1'b1);
        check("post_count", 32'(count), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
